// File: rtl/slowmem_arbiter_if.sv
// slowmem_arbiter_if: request/ack bundle for both cache ports plus the slow memory bus
interface slowmem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
        output ack0, rdata0, ack1, rdata1, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
        input  ack0, rdata0, ack1, rdata1, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/slowmem_arbiter.sv
// slowmem_arbiter: serializes two cache ports onto one slow memory; SLOWMEM_RR_EN selects round-robin over fixed priority
module slowmem_arbiter #(
    parameter int MEM_WAIT = 4,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    slowmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_id;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_ack0;
    logic              r_ack1;
    logic              w_req;
    logic              w_win;

    assign w_req = bus.req0 | bus.req1;
`ifdef SLOWMEM_RR_EN
    logic r_last;
    assign w_win = bus.req1 & (~bus.req0 | ~r_last);
`else
    assign w_win = bus.req1 & ~bus.req0;
`endif

    assign bus.mem_en    = r_state == BUSY;
    assign bus.mem_we    = (r_state == BUSY) & r_we & (r_cnt == 4'd0);
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.ack0      = r_ack0;
    assign bus.ack1      = r_ack1;
    assign bus.rdata0    = r_rdata0;
    assign bus.rdata1    = r_rdata1;

    // grant, count down the memory wait, then pulse the winner's ack for one cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_id     <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
`ifdef SLOWMEM_RR_EN
            r_last   <= 1'b1;
`endif
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                IDLE: if (w_req) begin
                    r_state <= BUSY;
                    r_id    <= w_win;
                    r_we    <= w_win ? bus.we1 : bus.we0;
                    r_addr  <= w_win ? bus.addr1 : bus.addr0;
                    r_wdata <= w_win ? bus.wdata1 : bus.wdata0;
                    r_cnt   <= 4'(MEM_WAIT - 1);
`ifdef SLOWMEM_RR_EN
                    r_last  <= w_win;
`endif
                end
                BUSY: if (r_cnt != 4'd0) begin
                    r_cnt <= r_cnt - 4'd1;
                end else begin
                    if (!r_we && !r_id) r_rdata0 <= bus.mem_rdata;
                    if (!r_we && r_id) r_rdata1 <= bus.mem_rdata;
                    r_ack0  <= ~r_id;
                    r_ack1  <= r_id;
                    r_state <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_slowmem_arbiter.sv
// tb_slowmem_arbiter: transaction-level model of the arbiter checked every cycle, plus directed literal checks
module tb_slowmem_arbiter;
    localparam int MW = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    slowmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    slowmem_arbiter #(.MEM_WAIT(MW), .ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, a, e);
        end
    endtask

    // slow memory array driven by the DUT, and the model's own copy of it
    logic [DW-1:0] mem [256];
    logic [DW-1:0] mm [256];
    assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
    always @(posedge clk) if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;

    // model: an access granted at edge g owns the memory for edges g..g+MW-1, acks after edge g+MW
    int n = 0;
    int g = 0;
    bit act = 0;
    bit sw = 0;
    bit swe = 0;
    bit last = 1;
    logic [AW-1:0] sa = '0;
    logic [DW-1:0] sd = '0;
    logic [DW-1:0] rd [2];

    always @(posedge clk) begin
        n++;
        if (!reset) begin
            act = 0; last = 1; rd[0] = '0; rd[1] = '0; sa = '0; sd = '0;
        end else begin
            if (act && n - g == MW) begin
                if (swe) mm[sa[7:0]] = sd;
                else rd[sw] = mm[sa[7:0]];
            end
            if ((!act || n - g >= MW + 2) && (bus.req0 || bus.req1)) begin
`ifdef SLOWMEM_RR_EN
                sw = (bus.req0 && bus.req1) ? !last : bus.req1;
`else
                sw = !bus.req0;
`endif
                last = sw;
                g = n;
                act = 1;
                swe = sw ? bus.we1 : bus.we0;
                sa = sw ? bus.addr1 : bus.addr0;
                sd = sw ? bus.wdata1 : bus.wdata0;
            end
        end
    end

    bit chk_en = 0;
    always @(negedge clk) if (chk_en) begin
        int k;
        bit busy, done;
        k = n - g;
        busy = act && k < MW;
        done = act && k == MW;
        chk("mem_en", bus.mem_en, busy);
        chk("mem_we", bus.mem_we, busy && swe && k == MW - 1);
        chk("mem_addr", bus.mem_addr, sa);
        chk("mem_wdata", bus.mem_wdata, sd);
        chk("ack0", bus.ack0, done && !sw);
        chk("ack1", bus.ack1, done && sw);
        chk("rdata0", bus.rdata0, rd[0]);
        chk("rdata1", bus.rdata1, rd[1]);
    end

    task automatic wait_ack(input int p, output int cyc, output int en, output int we, output logic [DW-1:0] wd);
        logic got;
        cyc = 0; en = 0; we = 0; wd = '0; got = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.mem_en) en++;
            if (bus.mem_we) begin we++; wd = bus.mem_wdata; end
            got = p ? bus.ack1 : bus.ack0;
        end
        chk("ack_seen", got, 1);
        if (p != 0) bus.req1 = 0;
        else bus.req0 = 0;
    endtask

    task automatic agent(input int p);
        logic r, a, upd;
        r = p ? bus.req1 : bus.req0;
        a = p ? bus.ack1 : bus.ack0;
        upd = 0;
        if (r && a) r = 0;
        else if (!r) begin r = ($urandom_range(0, 2) == 0); upd = r; end
        else upd = ($urandom_range(0, 5) == 0);
        if (p != 0) begin
            bus.req1 = r;
            if (upd) begin bus.we1 = 1'($urandom); bus.addr1 = {8'($urandom), 3'b0, 5'($urandom)}; bus.wdata1 = 16'($urandom); end
        end else begin
            bus.req0 = r;
            if (upd) begin bus.we0 = 1'($urandom); bus.addr0 = {8'($urandom), 3'b0, 5'($urandom)}; bus.wdata0 = 16'($urandom); end
        end
    endtask

    initial begin
        int cyc, en, we;
        logic [DW-1:0] wd;
        int order[$];
        int exp_order[4];
        bit re0, re1;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'(i * 3 + 1);
            mm[i] = 16'(i * 3 + 1);
        end
        mem[8'h12] = 16'hBEEF;
        mm[8'h12] = 16'hBEEF;
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0040; bus.wdata0 = '0;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 16'h0041; bus.wdata1 = '0;
        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        chk("rst_ack0", bus.ack0, 0);
        chk("rst_ack1", bus.ack1, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_rdata0", bus.rdata0, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        reset = 1;
        wait_ack(0, cyc, en, we, wd);
        chk("rst_first_port0_lat", cyc, MW + 1);
        wait_ack(1, cyc, en, we, wd);
        chk("waiting_port1_lat", cyc, MW + 2);
        chk("port1_rdata", bus.rdata1, 16'h00C4);
        repeat (2) @(negedge clk);

        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0012;
        wait_ack(0, cyc, en, we, wd);
        chk("read_lat", cyc, MW + 1);
        chk("read_en_cycles", en, MW);
        chk("read_we_cycles", we, 0);
        chk("read_rdata0", bus.rdata0, 16'hBEEF);
        chk("read_mem_addr", bus.mem_addr, 16'h0012);
        chk("read_ack1", bus.ack1, 0);
        @(negedge clk);
        chk("read_ack_pulse", bus.ack0, 0);
        @(negedge clk);

        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 16'h0007; bus.wdata1 = 16'h1234;
        wait_ack(1, cyc, en, we, wd);
        chk("write_we_cycles", we, 1);
        chk("write_wdata", wd, 16'h1234);
        chk("write_rdata1_kept", bus.rdata1, 16'h00C4);
        chk("write_mem", mem[7], 16'h1234);
        repeat (2) @(negedge clk);

        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0003;
        @(negedge clk);
        bus.addr0 = 16'h0009;
        repeat (MW - 1) begin
            @(negedge clk);
            chk("chg_mem_addr", bus.mem_addr, 16'h0003);
        end
        wait_ack(0, cyc, en, we, wd);
        chk("chg_rdata0", bus.rdata0, 16'h000A);
        repeat (2) @(negedge clk);

        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0050;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 16'h0051;
        re0 = 0; re1 = 0;
        for (int c = 0; c < 80 && order.size() < 4; c++) begin
            @(negedge clk);
            if (re0) begin bus.req0 = 1; re0 = 0; end
            if (re1) begin bus.req1 = 1; re1 = 0; end
            if (bus.ack0) begin order.push_back(0); bus.req0 = 0; re0 = order.size() < 4; end
            if (bus.ack1) begin order.push_back(1); bus.req1 = 0; re1 = order.size() < 4; end
        end
`ifdef SLOWMEM_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        chk("contend_count", order.size(), 4);
        for (int i = 0; i < 4; i++) chk("contend_order", (i < order.size()) ? order[i] : -1, exp_order[i]);
        bus.req0 = 0;
        if (bus.req1) wait_ack(1, cyc, en, we, wd);
        repeat (2) @(negedge clk);

        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 16'h0020; bus.wdata1 = 16'hAAAA;
        repeat (2) @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("abort_mem_en", bus.mem_en, 0);
        chk("abort_mem_we", bus.mem_we, 0);
        chk("abort_ack1", bus.ack1, 0);
        chk("abort_mem", mem[8'h20], 16'h0061);
        reset = 1;
        wait_ack(1, cyc, en, we, wd);
        chk("regrant_lat", cyc, MW + 1);
        chk("regrant_we", we, 1);
        chk("regrant_mem", mem[8'h20], 16'hAAAA);
        @(negedge clk);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 299) != 0);
            agent(0);
            agent(1);
        end
        reset = 1;
        bus.req0 = 0;
        bus.req1 = 0;
        repeat (MW + 3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
